uncached_write_buffer: RTL and testbench
========================================

Name: uncached_write_buffer

Overview:
- Posted store buffer on the uncached (conf) data path.
- Sits between the 1x2 data splitter's conf output and the 2x1 merge that feeds the AXI interface's data port.
- Acknowledges uncached stores upstream as soon as they are queued, then drains them downstream in order.
- Uncached loads are serialized behind pending stores so device-register ordering is preserved.

Parameters:
- DEPTH, 4: number of store entries. Power of two, range 2..16.
- PTR_W, $clog2(DEPTH): pointer width. Localparam, not overridable.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- up_req  in  1  upstream SRAM-like request
- up_wr  in  1  1 = store, 0 = load
- up_size  in  2  0 = byte, 1 = half, 2 = word
- up_addr  in  32  physical address
- up_wdata  in  32  store data
- up_rdata  out  32  load data
- up_addr_ok  out  1  request accepted this cycle
- up_data_ok  out  1  store acknowledge, or load data valid
- dn_req  out  1  downstream SRAM-like request
- dn_wr  out  1  downstream write flag
- dn_size  out  2  downstream size
- dn_addr  out  32  downstream address
- dn_wdata  out  32  downstream store data
- dn_rdata  in  32  downstream load data
- dn_addr_ok  in  1  downstream accepted
- dn_data_ok  in  1  downstream response
- busy  out  1  FIFO non-empty or downstream transaction outstanding

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low, on resetn.
- Reset values: all outputs 0, FIFO empty, count 0, state IDLE, store-ack flag 0. Asserting resetn low mid-transaction discards all entries and the in-flight transaction. No data_ok is generated afterwards for it.
- SRAM-like rules, both sides:
  - req is held until addr_ok.
  - Exactly one data_ok per accepted request, in acceptance order.
  - addr_ok and data_ok are single-cycle pulses.
- Store acceptance:
  - up_addr_ok = up_req & up_wr & (count < DEPTH) & ~rd_pend. Combinational.
  - Push {addr, size, wdata} on acceptance.
  - up_data_ok pulses exactly 1 cycle after acceptance, via a registered store-ack flag. up_rdata is don't-care on that cycle.
- Full FIFO: a store stalls (addr_ok = 0) even if a pop happens the same cycle. There is no push/pop bypass at full.
- Load acceptance (default): up_addr_ok = up_req & ~up_wr & (count == 0) & (state == IDLE) & ~store_ack_q. At most one load is outstanding (rd_pend).
- While rd_pend is set, no upstream request of any kind is accepted.
- Downstream FSM:
  - IDLE -> W_ADDR when count > 0. dn_* driven from the FIFO head, dn_req = 1.
  - IDLE -> R_ADDR when a load is accepted. Load addr/size are registered; dn_req asserts the next cycle.
  - W_ADDR: pop the head on dn_addr_ok, go to W_DATA.
  - W_DATA: on dn_data_ok -> IDLE. No upstream pulse is generated for it.
  - R_ADDR: on dn_addr_ok -> R_DATA.
  - R_DATA: on dn_data_ok, up_data_ok = 1 and up_rdata = dn_rdata, same cycle, combinational pass. Clear rd_pend, go to IDLE.
- Downstream outputs are stable while dn_req = 1 and dn_addr_ok = 0.
- Pointer wrap: head and tail wrap modulo DEPTH. count is PTR_W+1 bits wide.
- dn_data_ok arriving in IDLE, W_ADDR or R_ADDR is a protocol error. It is ignored; a simulation assertion fires.
- busy = (count != 0) | (state != IDLE).

Optional Feature:
- Macro: UCWB_READ_BYPASS_EN.
- Defined: a load may be accepted while the FIFO is non-empty, provided all of the following hold:
  - state == IDLE and ~store_ack_q;
  - no valid entry has addr[31:2] equal to up_addr[31:2];
  - the load takes priority over the FIFO head for the next downstream issue.
- Defined, address match: the load waits until the matching entries drain.
- Not defined: strict ordering. Loads wait for an empty FIFO and an IDLE FSM, as above.

Decomposition:
- Package ucwb_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD;
  - FSM state enum {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA};
  - typedef ucwb_entry_t {addr[31:0], size[1:0], wdata[31:0]}.
- Sub-module ucwb_fifo: DEPTH-entry register FIFO with push, pop, head, count, full and empty. With the bypass feature it also outputs a per-entry valid vector and an entry array for address matching.

Test Plan:
- Single store, addr 0x1FAF_F000, data 0xA5A5_0001, dn_addr_ok immediate:
  - up_addr_ok same cycle, up_data_ok next cycle;
  - dn_req with the same addr/data within 2 cycles;
  - busy drops after dn_data_ok.
- 5 back-to-back word stores with DEPTH = 4 and dn_addr_ok held low:
  - 4 accepted;
  - 5th stalls until the first pop, then is accepted;
  - downstream order 0,1,2,3,4.
- Store to 0x1FAF_F010, then load from 0x1FAF_F010:
  - load not accepted until the store's dn_data_ok;
  - load returns dn_rdata 0x0000_00FF on up_rdata with up_data_ok in the dn_data_ok cycle.
- Wrap-around: 10 stores with random dn latencies 0–3 → all 10 appear downstream in order with correct size/wdata; count returns to 0.
- resetn asserted low during W_DATA with 3 entries queued:
  - all outputs 0 immediately;
  - after release, no dn_req until a new request arrives.
- With UCWB_READ_BYPASS_EN, FIFO holding a store to 0x1FAF_F020:
  - load from 0x1FAF_F024 is issued downstream before that store;
  - load from 0x1FAF_F020 waits for that store to drain.

Source files
------------

// File: rtl/ucwb_pkg.sv
// Shared types for the uncached write buffer: size codes, downstream FSM
// states and the queued store entry layout.
package ucwb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    R_DATA
  } ucwb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } ucwb_entry_t;

  // Two accesses hit the same device word when they agree above the byte lane.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/ucwb_fifo.sv
// Register FIFO holding posted uncached stores.
// With UCWB_READ_BYPASS_EN defined it also exposes the storage array and a
// per-slot valid vector so the top level can look for address hits.
module ucwb_fifo
  import ucwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      push,
  input  ucwb_entry_t               push_entry,
  input  logic                      pop,
  output ucwb_entry_t               head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
`ifdef UCWB_READ_BYPASS_EN
  ,
  output logic [DEPTH-1:0]          valid,
  output ucwb_entry_t               entries [DEPTH]
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  ucwb_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  // A push at full is refused even if the head leaves this cycle.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[head_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless outside the head..tail window.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_entry;
  end

`ifdef UCWB_READ_BYPASS_EN
  assign entries = mem;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(i) - head_ptr} < count);
    end
  end
`endif

endmodule

// File: rtl/uncached_write_buffer.sv
// Posted store buffer on the uncached data path. Stores are acknowledged as
// soon as they are queued and drained downstream in order; loads are held
// behind pending stores so device-register ordering is preserved.
// Optional: UCWB_READ_BYPASS_EN lets a load overtake queued stores to other words.
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | nothing outstanding downstream
// W_ADDR | FIFO head presented downstream, waiting for addr_ok
// W_DATA | store accepted downstream, waiting for its data_ok
// R_ADDR | load presented downstream, waiting for addr_ok
// R_DATA | load accepted downstream, waiting for its data
module uncached_write_buffer
  import ucwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        up_req,
  input  logic        up_wr,
  input  logic [1:0]  up_size,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  output logic [31:0] up_rdata,
  output logic        up_addr_ok,
  output logic        up_data_ok,
  output logic        dn_req,
  output logic        dn_wr,
  output logic [1:0]  dn_size,
  output logic [31:0] dn_addr,
  output logic [31:0] dn_wdata,
  input  logic [31:0] dn_rdata,
  input  logic        dn_addr_ok,
  input  logic        dn_data_ok,
  output logic        busy
);

  localparam int PTR_W = $clog2(DEPTH);

  ucwb_state_t  state;
  logic         store_ack_q;
  logic         rd_pend;
  logic [PTR_W:0] count;
  logic         full;
  logic         empty;
  ucwb_entry_t  head;
  ucwb_entry_t  push_entry;
  logic         store_acc;
  logic         load_ok;
  logic         load_acc;
  logic         pop;
  logic         rd_done;

  assign push_entry = {up_addr, up_size, up_wdata};
  assign store_acc  = up_req & up_wr & ~full & ~rd_pend;
  assign load_acc   = up_req & ~up_wr & ~rd_pend & load_ok;
  assign up_addr_ok = store_acc | load_acc;
  assign pop        = (state == W_ADDR) & dn_addr_ok;
  assign rd_done    = (state == R_DATA) & dn_data_ok;
  assign up_data_ok = store_ack_q | rd_done;
  assign up_rdata   = rd_done ? dn_rdata : '0;
  assign busy       = (count != '0) | (state != IDLE);

`ifdef UCWB_READ_BYPASS_EN
  logic [DEPTH-1:0] valid;
  ucwb_entry_t      entries [DEPTH];
  logic             addr_hit;

  // A load must not pass a queued store to the same word.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && same_word(entries[i].addr, up_addr)) addr_hit = 1'b1;
    end
  end

  assign load_ok = (state == IDLE) & ~store_ack_q & (empty | ~addr_hit);
`else
  assign load_ok = empty & (state == IDLE) & ~store_ack_q;
`endif

  ucwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (store_acc),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef UCWB_READ_BYPASS_EN
    ,
    .valid      (valid),
    .entries    (entries)
`endif
  );

  // Store ack follows acceptance by one cycle; one load may be outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      store_ack_q <= 1'b0;
      rd_pend     <= 1'b0;
    end else begin
      store_ack_q <= store_acc;
      if (load_acc)     rd_pend <= 1'b1;
      else if (rd_done) rd_pend <= 1'b0;
    end
  end

  // Downstream sequencer; dn_* are captured on issue so they hold until addr_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      dn_req   <= 1'b0;
      dn_wr    <= 1'b0;
      dn_size  <= '0;
      dn_addr  <= '0;
      dn_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_acc) begin
            state    <= R_ADDR;
            dn_req   <= 1'b1;
            dn_wr    <= 1'b0;
            dn_size  <= up_size;
            dn_addr  <= up_addr;
            dn_wdata <= '0;
          end else if (!empty) begin
            state    <= W_ADDR;
            dn_req   <= 1'b1;
            dn_wr    <= 1'b1;
            dn_size  <= head.size;
            dn_addr  <= head.addr;
            dn_wdata <= head.wdata;
          end
        end
        W_ADDR: begin
          if (dn_addr_ok) begin
            dn_req <= 1'b0;
            state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (dn_data_ok) state <= IDLE;
        end
        R_ADDR: begin
          if (dn_addr_ok) begin
            dn_req <= 1'b0;
            state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (dn_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A downstream response is only legal during a data phase; it is ignored otherwise.
  always_ff @(posedge clk) begin
    if (resetn && dn_data_ok) begin
      assert (state == W_DATA || state == R_DATA)
        else $error("ucwb: dn_data_ok outside a data phase");
    end
  end
`endif

endmodule

// File: tb/tb_uncached_write_buffer.sv
`timescale 1ns/1ps
module tb_uncached_write_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        up_req;
  logic        up_wr;
  logic [1:0]  up_size;
  logic [31:0] up_addr;
  logic [31:0] up_wdata;
  logic [31:0] up_rdata;
  logic        up_addr_ok;
  logic        up_data_ok;
  logic        dn_req;
  logic        dn_wr;
  logic [1:0]  dn_size;
  logic [31:0] dn_addr;
  logic [31:0] dn_wdata;
  logic [31:0] dn_rdata;
  logic        dn_addr_ok;
  logic        dn_data_ok;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // downstream responder controls and transaction log
  int          lat_a = 0;
  int          lat_d = 0;
  bit          slv_en = 1'b1;
  bit          slv_rand = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [1:0]  log_size[$];
  logic        log_wr[$];

  uncached_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .up_req     (up_req),
    .up_wr      (up_wr),
    .up_size    (up_size),
    .up_addr    (up_addr),
    .up_wdata   (up_wdata),
    .up_rdata   (up_rdata),
    .up_addr_ok (up_addr_ok),
    .up_data_ok (up_data_ok),
    .dn_req     (dn_req),
    .dn_wr      (dn_wr),
    .dn_size    (dn_size),
    .dn_addr    (dn_addr),
    .dn_wdata   (dn_wdata),
    .dn_rdata   (dn_rdata),
    .dn_addr_ok (dn_addr_ok),
    .dn_data_ok (dn_data_ok),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic up_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input int max_wait, output int waited);
    up_req = 1'b1; up_wr = 1'b1; up_addr = a; up_wdata = d; up_size = s;
    waited = 0;
    forever begin
      @(negedge clk);
      if (up_addr_ok) break;
      if (waited >= max_wait) begin waited = -1; break; end
      waited++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    up_req = 1'b0;
  endtask

  task automatic up_load(input logic [31:0] a, input int max_wait, output int waited,
                         output logic busy_at_acc);
    up_req = 1'b1; up_wr = 1'b0; up_addr = a; up_wdata = 32'h0; up_size = 2'd2;
    waited = 0; busy_at_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (up_addr_ok) begin busy_at_acc = busy; break; end
      if (waited >= max_wait) begin waited = -1; break; end
      waited++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    up_req = 1'b0;
  endtask

  task automatic wait_rd(input int max, output logic got, output logic [31:0] rd, output logic dok);
    got = 1'b0; rd = 32'h0; dok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (up_data_ok) begin got = 1'b1; rd = up_rdata; dok = dn_data_ok; break; end
    end
  endtask

  task automatic wait_idle(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_wdata.delete(); log_size.delete(); log_wr.delete();
  endtask

  // Downstream SRAM-like slave with programmable or random latencies.
  initial begin
    int aw;
    int dw;
    bit in_data;
    aw = -1; dw = 0; in_data = 1'b0;
    dn_addr_ok = 1'b0; dn_data_ok = 1'b0; dn_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dn_addr_ok = 1'b0;
      dn_data_ok = 1'b0;
      if (!resetn) begin
        aw = -1; in_data = 1'b0;
      end else if (in_data) begin
        if (dw == 0) begin
          dn_data_ok = 1'b1; dn_rdata = slv_rdata; in_data = 1'b0;
        end else dw--;
      end else if (dn_req && slv_en) begin
        if (aw < 0) aw = slv_rand ? int'($urandom_range(0, 3)) : lat_a;
        if (aw == 0) begin
          dn_addr_ok = 1'b1; aw = -1; in_data = 1'b1;
          dw = slv_rand ? int'($urandom_range(0, 3)) : lat_d;
          log_addr.push_back(dn_addr);
          log_wdata.push_back(dn_wdata);
          log_size.push_back(dn_size);
          log_wr.push_back(dn_wr);
        end else aw--;
      end
    end
  end

  // Every cycle: up_data_ok exactly one cycle after a store acceptance, or
  // together with the data_ok that answers the downstream load.
  bit prev_st_acc = 1'b0;
  bit rd_issued = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_st_acc = 1'b0;
      rd_issued   = 1'b0;
    end else begin
      logic exp_ok;
      exp_ok = prev_st_acc | (rd_issued & dn_data_ok);
      chk("up_data_ok_pulse", 32'(up_data_ok), 32'(exp_ok));
      if (rd_issued && dn_data_ok) begin
        chk("load_rdata_pass", up_rdata, dn_rdata);
        rd_issued = 1'b0;
      end
      if (dn_req && !dn_wr && dn_addr_ok) rd_issued = 1'b1;
      prev_st_acc = up_req & up_wr & up_addr_ok;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic        b;
    logic        ok;
    logic        got;
    logic        dok;
    logic        anyreq;
    logic        exp_busy_acc;
    logic [31:0] rd;
    logic [31:0] exp_d[10];
    logic [1:0]  exp_s[10];
    logic [31:0] o_addr[3];
    logic        o_wr[3];

    resetn = 1'b0; up_req = 1'b0; up_wr = 1'b0; up_size = 2'd0;
    up_addr = 32'h0; up_wdata = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dn_req", 32'(dn_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_up_data_ok", 32'(up_data_ok), 32'd0);
    chk("rst_up_addr_ok", 32'(up_addr_ok), 32'd0);
    chk("rst_dn_addr", dn_addr, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    sync();

    // single store, immediate addr_ok
    clear_log();
    lat_a = 0; lat_d = 1; slv_en = 1'b1; slv_rand = 1'b0;
    up_store(32'h1FAF_F000, 32'hA5A5_0001, 2'd2, 5, w);
    chk("t1_accept_wait", 32'(w), 32'd0);
    @(negedge clk);
    chk("t1_store_ack", 32'(up_data_ok), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_dn_req_early", 32'(dn_req), 32'd0);
    @(negedge clk);
    chk("t1_dn_req", 32'(dn_req), 32'd1);
    chk("t1_dn_addr", dn_addr, 32'h1FAF_F000);
    chk("t1_dn_wdata", dn_wdata, 32'hA5A5_0001);
    chk("t1_dn_wr", 32'(dn_wr), 32'd1);
    chk("t1_dn_size", 32'(dn_size), 32'd2);
    wait_idle(20, ok);
    chk("t1_idle", 32'(ok), 32'd1);
    chk("t1_log_len", 32'(log_addr.size()), 32'd1);
    sync();

    // five stores, downstream stalled: fifth waits for the first pop
    clear_log();
    lat_a = 0; lat_d = 0; slv_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_store(32'h1000_0000 + 32'(4 * i), 32'hD000_0000 + 32'(i), 2'd2, 5, w);
      chk("t2_accept", 32'(w), 32'd0);
    end
    up_store(32'h1000_0010, 32'hD000_0004, 2'd2, 4, w);
    chk("t2_fifth_stalls", 32'(w), 32'hFFFF_FFFF);
    @(negedge clk);
    slv_en = 1'b1;
    sync();
    up_store(32'h1000_0010, 32'hD000_0004, 2'd2, 20, w);
    chk("t2_no_bypass_at_full", 32'(w), 32'd1);
    wait_idle(80, ok);
    chk("t2_idle", 32'(ok), 32'd1);
    chk("t2_log_len", 32'(log_addr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_order_addr", log_addr[i], 32'h1000_0000 + 32'(4 * i));
      chk("t2_order_data", log_wdata[i], 32'hD000_0000 + 32'(i));
    end
    sync();

    // store then load to the same register
    clear_log();
    lat_a = 0; lat_d = 2; slv_rdata = 32'h0000_00FF;
    up_store(32'h1FAF_F010, 32'h0000_0077, 2'd2, 5, w);
    chk("t3_store_accept", 32'(w), 32'd0);
    up_load(32'h1FAF_F010, 30, w, b);
    chk("t3_load_wait", 32'(w), 32'd5);
    chk("t3_load_after_drain", 32'(b), 32'd0);
    wait_rd(20, got, rd, dok);
    chk("t3_load_done", 32'(got), 32'd1);
    chk("t3_load_rdata", rd, 32'h0000_00FF);
    chk("t3_same_cycle", 32'(dok), 32'd1);
    wait_idle(20, ok);
    chk("t3_idle", 32'(ok), 32'd1);
    chk("t3_log_len", 32'(log_addr.size()), 32'd2);
    chk("t3_first_wr", 32'(log_wr[0]), 32'd1);
    chk("t3_second_rd", 32'(log_wr[1]), 32'd0);
    chk("t3_rd_addr", log_addr[1], 32'h1FAF_F010);
    sync();

    // pointer wrap with random downstream latency
    clear_log();
    slv_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_d[i] = $urandom();
      exp_s[i] = 2'(i % 3);
      up_store(32'h2000_0000 + 32'(4 * i), exp_d[i], exp_s[i], 100, w);
      chk("t4_accept", 32'(w >= 0), 32'd1);
    end
    wait_idle(300, ok);
    chk("t4_idle", 32'(ok), 32'd1);
    chk("t4_log_len", 32'(log_addr.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("t4_addr", log_addr[i], 32'h2000_0000 + 32'(4 * i));
      chk("t4_wdata", log_wdata[i], exp_d[i]);
      chk("t4_size", 32'(log_size[i]), 32'(exp_s[i]));
    end
    slv_rand = 1'b0;
    sync();

    // reset during W_DATA with three stores queued
    lat_a = 0; lat_d = 40;
    for (int i = 0; i < 4; i++) begin
      up_store(32'h3000_0000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'd2, 10, w);
      chk("t5_accept", 32'(w), 32'd0);
    end
    repeat (2) @(posedge clk);
    #3;
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_dn_addr", dn_addr, 32'h3000_0000);
    chk("t5_pre_dn_wr", 32'(dn_wr), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_dn_req", 32'(dn_req), 32'd0);
    chk("t5_dn_addr", dn_addr, 32'd0);
    chk("t5_dn_wdata", dn_wdata, 32'd0);
    chk("t5_dn_wr", 32'(dn_wr), 32'd0);
    chk("t5_up_data_ok", 32'(up_data_ok), 32'd0);
    repeat (3) @(posedge clk);
    clear_log();
    lat_d = 0;
    #1;
    resetn = 1'b1;
    anyreq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      anyreq = anyreq | dn_req | busy;
    end
    chk("t5_quiet_after_reset", 32'(anyreq), 32'd0);
    chk("t5_log_empty", 32'(log_addr.size()), 32'd0);
    sync();
    up_store(32'h3000_0100, 32'h5555_AAAA, 2'd2, 5, w);
    chk("t5_new_accept", 32'(w), 32'd0);
    wait_idle(20, ok);
    chk("t5_new_idle", 32'(ok), 32'd1);
    chk("t5_new_len", 32'(log_addr.size()), 32'd1);
    chk("t5_new_addr", log_addr[0], 32'h3000_0100);
    chk("t5_new_wdata", log_wdata[0], 32'h5555_AAAA);
    sync();

    // load to another word versus queued store
`ifdef UCWB_READ_BYPASS_EN
    o_addr[0] = 32'h1FAF_F000; o_wr[0] = 1'b1;
    o_addr[1] = 32'h1FAF_F024; o_wr[1] = 1'b0;
    o_addr[2] = 32'h1FAF_F020; o_wr[2] = 1'b1;
    exp_busy_acc = 1'b1;
`else
    o_addr[0] = 32'h1FAF_F000; o_wr[0] = 1'b1;
    o_addr[1] = 32'h1FAF_F020; o_wr[1] = 1'b1;
    o_addr[2] = 32'h1FAF_F024; o_wr[2] = 1'b0;
    exp_busy_acc = 1'b0;
`endif
    clear_log();
    lat_a = 3; lat_d = 0; slv_rdata = 32'h1234_5678;
    up_store(32'h1FAF_F000, 32'h0000_0011, 2'd2, 5, w);
    up_store(32'h1FAF_F020, 32'h0000_0022, 2'd2, 5, w);
    up_load(32'h1FAF_F024, 60, w, b);
    chk("t6_other_acc", 32'(w >= 0), 32'd1);
    chk("t6_other_busy", 32'(b), 32'(exp_busy_acc));
    wait_rd(40, got, rd, dok);
    chk("t6_other_rdata", rd, 32'h1234_5678);
    wait_idle(60, ok);
    chk("t6_other_idle", 32'(ok), 32'd1);
    chk("t6_other_len", 32'(log_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t6_other_addr", log_addr[i], o_addr[i]);
      chk("t6_other_wr", 32'(log_wr[i]), 32'(o_wr[i]));
    end
    sync();

    // load to the queued store's word waits for it in every build
    clear_log();
    up_store(32'h1FAF_F000, 32'h0000_0033, 2'd2, 5, w);
    up_store(32'h1FAF_F020, 32'h0000_0044, 2'd2, 5, w);
    up_load(32'h1FAF_F020, 60, w, b);
    chk("t6_hit_acc", 32'(w >= 0), 32'd1);
    chk("t6_hit_busy", 32'(b), 32'd0);
    wait_rd(40, got, rd, dok);
    chk("t6_hit_done", 32'(got), 32'd1);
    wait_idle(60, ok);
    chk("t6_hit_len", 32'(log_addr.size()), 32'd3);
    chk("t6_hit_store_first", log_addr[1], 32'h1FAF_F020);
    chk("t6_hit_store_data", log_wdata[1], 32'h0000_0044);
    chk("t6_hit_load_last", 32'(log_wr[2]), 32'd0);
    chk("t6_hit_load_addr", log_addr[2], 32'h1FAF_F020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
